crypto_sig_verify_q: RTL

Parametrised, queued successor to the single-shot Ed25519 verify model. Accepts tagged verify requests over a valid/ready interface and buffers them in a DEPTH-entry FIFO. A single verify engine with fixed LATENCY processes them in order and returns tagged results over a valid/ready interface. Sits between the boot/update controller and the (future) real Ed25519 core; the check function is selected by MODE so the same shell serves sim, bring-up and fail-closed builds.

---
 rtl/crypto_sig_verify_q.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/crypto_sig_verify_q.sv
// Queued signature-verify shell: DEPTH-entry request FIFO feeding a fixed-latency check engine.
// Optional per-build statistics counters are enabled with `define SIGV_STATS_EN.
module crypto_sig_verify_q #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 8,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MODE    = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [TAG_W-1:0]           req_tag_i,
    input  logic [255:0]               req_pubkey_i,
    input  logic [511:0]               req_sig_i,
    input  logic [255:0]               req_hash_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [TAG_W-1:0]           rsp_tag_o,
    output logic                       rsp_ok_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     pending_o
`ifdef SIGV_STATS_EN
    ,
    output logic [15:0]                stat_ok_o,
    output logic [15:0]                stat_fail_o,
    output logic [15:0]                stat_drop_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    function automatic logic check_sig(input logic [255:0] pk,
                                       input logic [255:0] sig_lo,
                                       input logic [255:0] hash);
        if (MODE == 1)      return ((sig_lo ^ pk) == hash);
        else if (MODE == 2) return 1'b1;
        else                return 1'b0;
    endfunction

    state_e              state;
    logic [CW-1:0]       cnt;
    logic [TAG_W-1:0]    eng_tag;
    logic                eng_ok;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [TAG_W:0]      mem [DEPTH];

    logic                full;
    logic                push;
    logic                pop;
    logic                req_ok;
    logic                engine_active_n;
    logic [PW-1:0]       count_n;
    logic                unused_sig_hi;

    assign unused_sig_hi = ^req_sig_i[511:256];

    // The check is a pure function of the request, so it is evaluated once at
    // enqueue and only {tag, ok} is queued; results and timing are unchanged.
    assign req_ok      = check_sig(req_pubkey_i, req_sig_i[255:0], req_hash_i);
    assign full        = (pending_o == PW'(DEPTH));
    assign req_ready_o = !full && !flush_i;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state == S_IDLE) && (pending_o != '0) && !flush_i;

    always_comb begin
        count_n         = '0;
        engine_active_n = 1'b0;
        if (!flush_i) begin
            count_n = pending_o + PW'(push) - PW'(pop);
            unique case (state)
                S_IDLE:  engine_active_n = pop;
                S_BUSY:  engine_active_n = 1'b1;
                S_DONE:  engine_active_n = !rsp_ready_i;
                default: engine_active_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {req_tag_i, req_ok};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            cnt         <= '0;
            eng_tag     <= '0;
            eng_ok      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_tag_o   <= '0;
            rsp_ok_o    <= 1'b0;
            busy_o      <= 1'b0;
            pending_o   <= '0;
        end else begin
            busy_o    <= engine_active_n || (count_n != '0);
            pending_o <= count_n;
            if (flush_i) begin
                state       <= S_IDLE;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                rsp_valid_o <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case (state)
                    S_IDLE: begin
                        if (pop) begin
                            {eng_tag, eng_ok} <= mem[rd_ptr];
                            cnt               <= CW'(LATENCY - 1);
                            state             <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (cnt == '0) begin
                            rsp_tag_o   <= eng_tag;
                            rsp_ok_o    <= eng_ok;
                            rsp_valid_o <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (rsp_ready_i) begin
                            rsp_valid_o <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SIGV_STATS_EN
    logic rsp_hs;
    logic drop_ev;

    // A flush wins over a same-cycle handshake, so that response is a drop.
    assign rsp_hs  = rsp_valid_o && rsp_ready_i && !flush_i;
    assign drop_ev = flush_i && ((state != S_IDLE) || (pending_o != '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_ok_o   <= '0;
            stat_fail_o <= '0;
            stat_drop_o <= '0;
        end else begin
            if (rsp_hs && rsp_ok_o && (stat_ok_o != '1))
                stat_ok_o <= stat_ok_o + 1'b1;
            if (rsp_hs && !rsp_ok_o && (stat_fail_o != '1))
                stat_fail_o <= stat_fail_o + 1'b1;
            if (drop_ev && (stat_drop_o != '1))
                stat_drop_o <= stat_drop_o + 1'b1;
        end
    end
`endif

endmodule
